// File: rtl/current_clarke_park_if.sv
// Data/handshake bundle between the current-sense front end and its user.
// The master drives the phase currents, the angle and the conversion request.
// The slave (the transform block) returns id/iq, busy and the done pulse.
interface current_clarke_park_if;
  logic signed [11:0] iIa;
  logic signed [11:0] iIb;
  logic signed [15:0] iSin;
  logic signed [15:0] iCos;
  logic               iConv_en;
  logic signed [11:0] oCurrent_d;
  logic signed [11:0] oCurrent_q;
  logic               oBusy;
  logic               oCal_done;

  modport master (
    output iIa, iIb, iSin, iCos, iConv_en,
    input  oCurrent_d, oCurrent_q, oBusy, oCal_done
  );

  modport slave (
    input  iIa, iIb, iSin, iCos, iConv_en,
    output oCurrent_d, oCurrent_q, oBusy, oCal_done
  );
endinterface

// File: rtl/current_clarke_park.sv
// Clarke + Park transform of two measured phase currents into rotor-frame id/iq.
// A rising edge on iConv_en in IDLE launches a fixed 5-edge multi-cycle pipeline;
// results are floor-shifted, clamped to +/-I_LIM and flagged by a one-cycle done.
module current_clarke_park #(
  parameter logic signed [15:0] K_INV_SQRT3 = 16'sd18919,
  parameter logic signed [11:0] I_LIM       = 12'sd2047
) (
  input logic                  iClk,
  input logic                  iRst_n,
  current_clarke_park_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StBetaMul,
    StBetaSh,
    StParkMul,
    StParkSum,
    StOut
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic               r_en_pre;
  logic               w_start;

  logic signed [11:0] r_ia;
  logic signed [15:0] r_sin;
  logic signed [15:0] r_cos;
  logic signed [13:0] r_sum_ab;
  logic signed [29:0] r_pb;
  logic signed [12:0] r_ibeta;
  logic signed [11:0] r_ialpha;
  logic signed [28:0] r_p_ac;  // ialpha * cos
  logic signed [28:0] r_p_bs;  // ibeta  * sin
  logic signed [28:0] r_p_bc;  // ibeta  * cos
  logic signed [28:0] r_p_as;  // ialpha * sin
  logic signed [31:0] r_sd;
  logic signed [31:0] r_sq;
  logic signed [11:0] r_cur_d;
  logic signed [11:0] r_cur_q;
  logic               r_cal_done;

  logic signed [16:0] w_d_raw;
  logic signed [16:0] w_q_raw;
  logic signed [11:0] w_d_sat;
  logic signed [11:0] w_q_sat;

  // Symmetric clamp; -2048 is deliberately unreachable so the loop sees a balanced range.
  function automatic logic signed [11:0] sat_ilim(input logic signed [16:0] v);
    logic signed [16:0] lim;
    lim = 17'(I_LIM);
    if (v > lim) begin
      sat_ilim = I_LIM;
    end else if (v < -lim) begin
      sat_ilim = -I_LIM;
    end else begin
      sat_ilim = 12'(v);
    end
  endfunction

  // Only a fresh edge seen while idle starts a conversion; others are dropped.
  assign w_start = bus.iConv_en & ~r_en_pre;

  // Floor shift back to ADC counts; the sum never exceeds 17 significant bits.
  assign w_d_raw = 17'(r_sd >>> 15);
  assign w_q_raw = 17'(r_sq >>> 15);
  assign w_d_sat = sat_ilim(w_d_raw);
  assign w_q_sat = sat_ilim(w_q_raw);

  assign bus.oCurrent_d = r_cur_d;
  assign bus.oCurrent_q = r_cur_q;
  assign bus.oBusy      = (r_state != StIdle);
  assign bus.oCal_done  = r_cal_done;

  // State register and request-edge history.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= StIdle;
      r_en_pre <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_en_pre <= bus.iConv_en;
    end
  end

  // Next-state: a straight sequence once started, back to idle after the output step.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_start) w_state_next = StBetaMul;
      StBetaMul: w_state_next = StBetaSh;
      StBetaSh:  w_state_next = StParkMul;
      StParkMul: w_state_next = StParkSum;
      StParkSum: w_state_next = StOut;
      StOut:     w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Datapath: each state owns one arithmetic step; outputs update only in OUT.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_ia       <= '0;
      r_sin      <= '0;
      r_cos      <= '0;
      r_sum_ab   <= '0;
      r_pb       <= '0;
      r_ibeta    <= '0;
      r_ialpha   <= '0;
      r_p_ac     <= '0;
      r_p_bs     <= '0;
      r_p_bc     <= '0;
      r_p_as     <= '0;
      r_sd       <= '0;
      r_sq       <= '0;
      r_cur_d    <= '0;
      r_cur_q    <= '0;
      r_cal_done <= 1'b0;
    end else begin
      r_cal_done <= (r_state == StOut);
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_ia     <= bus.iIa;
            r_sin    <= bus.iSin;
            r_cos    <= bus.iCos;
            r_sum_ab <= 14'(bus.iIa) + (14'(bus.iIb) <<< 1);
          end
        end
        StBetaMul: begin
          r_pb <= 30'(r_sum_ab) * 30'(K_INV_SQRT3);
        end
        StBetaSh: begin
          r_ibeta  <= 13'(r_pb >>> 15);
          r_ialpha <= r_ia;
        end
        StParkMul: begin
          r_p_ac <= 29'(r_ialpha) * 29'(r_cos);
          r_p_bs <= 29'(r_ibeta) * 29'(r_sin);
          r_p_bc <= 29'(r_ibeta) * 29'(r_cos);
          r_p_as <= 29'(r_ialpha) * 29'(r_sin);
        end
        StParkSum: begin
          r_sd <= 32'(r_p_ac) + 32'(r_p_bs);
          r_sq <= 32'(r_p_bc) - 32'(r_p_as);
        end
        StOut: begin
          r_cur_d <= w_d_sat;
          r_cur_q <= w_q_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/current_clarke_park.md
Name: current_clarke_park

Overview:
- Measured-current front end of the FOC current loop.
- Converts two ADC phase currents (ia, ib) and the electrical-angle sin/cos into rotor-frame id/iq using the Clarke then Park transform.
- Outputs are saturated to the current-loop error range and delivered with a start/done handshake.
- oCurrent_d/q feed the PI current loop's measured-current inputs. oCal_done is wired directly to that loop's rising-edge-triggered calculation enable.

Parameters:
- K_INV_SQRT3, 16'sd18919, 1/sqrt(3) in Q15.
- I_LIM, 12'sd2047, symmetric output clamp magnitude.

Ports:
- iClk  input  1  system clock
- iRst_n  input  1  asynchronous active-low reset
- iIa  input  12  phase A current, signed ADC counts
- iIb  input  12  phase B current, signed ADC counts
- iSin  input  16  sin(theta_e), signed Q15
- iCos  input  16  cos(theta_e), signed Q15
- iConv_en  input  1  conversion request; rising edge starts a conversion
- oCurrent_d  output  12  id, signed
- oCurrent_q  output  12  iq, signed
- oBusy  output  1  high while a conversion is in progress
- oCal_done  output  1  one-cycle pulse when oCurrent_d/q update

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous, active-low, on iRst_n.
- Reset values: all outputs 0, FSM in IDLE, all internal registers 0.
- Start detection:
  - iConv_en is registered every cycle into en_pre.
  - Start = iConv_en & !en_pre, sampled only in IDLE.
  - Holding iConv_en high never retriggers a conversion.
  - Starts arriving while not in IDLE are dropped, not queued.
- FSM states: IDLE, BETA_MUL, BETA_SH, PARK_MUL, PARK_SUM, OUT.
  - IDLE: on start, latch iIa, iIb, iSin, iCos and sum_ab = ia + 2*ib (14-bit signed); go to BETA_MUL.
  - BETA_MUL: pb = sum_ab * K_INV_SQRT3 (30-bit signed).
  - BETA_SH: ibeta = pb >>> 15 (arithmetic, floor), held as a 13-bit signed value; ialpha = ia.
  - PARK_MUL: compute four signed products, each 29-bit: ialpha*cos, ibeta*sin, ibeta*cos, ialpha*sin.
  - PARK_SUM: sd = ialpha*cos + ibeta*sin; sq = ibeta*cos - ialpha*sin. Both use 32-bit signed accumulators.
  - OUT: d = sd >>> 15, q = sq >>> 15 (floor). Each is clamped to [-I_LIM, +I_LIM], so -2048 is never output. oCurrent_d and oCurrent_q update together. oCal_done = 1 this cycle only. Next state is IDLE.
- oBusy is high in every state except IDLE.
- Latency: the start edge samples the inputs at clock edge 0. Outputs update and oCal_done rises at clock edge 5. A new start is accepted at edge 6 at the earliest.
- Outputs hold their value between conversions.
- oCal_done is low in every cycle except the OUT cycle, so consecutive conversions produce distinct rising edges.
- Input changes after edge 0 do not affect the conversion in flight.
- Reset mid-conversion: abort immediately, outputs return to 0, no oCal_done pulse. The first start after reset release requires a fresh rising edge; en_pre resets to 0, so iConv_en high at release counts as an edge.
- Rounding: all shifts truncate toward minus infinity. There is no rounding offset.

Test Plan:
- ia=1000, ib=0, sin=0, cos=32767, single start -> ibeta=577; oCurrent_d=999, oCurrent_q=576; oCal_done high exactly at edge 5, one cycle.
- ia=1000, ib=0, sin=32767, cos=0 -> oCurrent_d=576, oCurrent_q=-1000.
- ia=2047, ib=2047, sin=cos=23170 -> ibeta=3545; raw d=3954 clamps to oCurrent_d=2047; oCurrent_q=1059.
- ia=-2048, ib=-2048, sin=0, cos=32767 -> ibeta=-3548; raw d=-2048 and raw q=-3548; both clamp to -2047.
- iConv_en held high 20 cycles, plus a second rising edge at edge 3 -> exactly one oCal_done pulse; oBusy high edges 1..5. A new edge at edge 7 is accepted, done pulses at edge 12.
- Assert iRst_n low at edge 3 of a conversion -> outputs 0, no done pulse. After release, an iConv_en edge yields a correct result 5 cycles later.
